bottle_counter: RTL

- Front-end stage of the return-and-earn machine: classifies each inserted bottle from the inlet size sensor and keeps per-size session counts.
- Its three 12-bit count outputs feed the money calculation stage directly. That stage weights 250 ml = 1, 500 ml = 2 and 1250 ml = 3 credits.
- Counts are cleared by the payout controller at the end of each session.

---
 rtl/bottle_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bottle_counter.sv
// Inlet bottle classifier with per-size session counts for the return-and-earn machine.
// Define BOTTLE_CREDIT_CAP_EN to also cap the weighted credit total at 4095.
module bottle_counter #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bottle_detect,
  input  logic [1:0]  size_code,
  input  logic        session_clear,
  output logic [11:0] bottle_250ml_counter,
  output logic [11:0] bottle_500ml_counter,
  output logic [11:0] bottle_1250ml_counter,
  output logic        bottle_accept,
  output logic        bottle_reject,
  output logic        busy
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StAccept, StReject, StRelease} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [1:0]    last_q, last_d;
  logic [11:0]   c250_q, c250_d, c500_q, c500_d, c1250_q, c1250_d;
  logic          accept_q, accept_d, reject_q, reject_d;
  logic          sel_full, commit_ok;

  always_comb begin
    unique case (last_q)
      2'b01:   sel_full = (c250_q == 12'hfff);
      2'b10:   sel_full = (c500_q == 12'hfff);
      2'b11:   sel_full = (c1250_q == 12'hfff);
      default: sel_full = 1'b0;
    endcase
  end

`ifdef BOTTLE_CREDIT_CAP_EN
  logic [13:0] credit_q, credit_d, weight;

  always_comb begin
    unique case (last_q)
      2'b01:   weight = 14'd1;
      2'b10:   weight = 14'd2;
      2'b11:   weight = 14'd3;
      default: weight = 14'd0;
    endcase
  end

  assign commit_ok = !sel_full && ((credit_q + weight) <= 14'd4095);
`else
  assign commit_ok = !sel_full;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      stable_q  <= '0;
      timeout_q <= '0;
      last_q    <= 2'b00;
      c250_q    <= '0;
      c500_q    <= '0;
      c1250_q   <= '0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
`ifdef BOTTLE_CREDIT_CAP_EN
      credit_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      c250_q    <= c250_d;
      c500_q    <= c500_d;
      c1250_q   <= c1250_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
`ifdef BOTTLE_CREDIT_CAP_EN
      credit_q  <= credit_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    last_d    = last_q;
    unique case (state_q)
      StIdle: begin
        stable_d  = '0;
        timeout_d = '0;
        last_d    = size_code;
        if (bottle_detect) state_d = StSettle;
      end
      StSettle: begin
        timeout_d = timeout_q + TW'(1);
        if (!bottle_detect) begin
          state_d = StIdle;
        end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StReject;
        end else if ((size_code != last_q) || (size_code == 2'b00)) begin
          stable_d = '0;
          last_d   = size_code;
        end else if (stable_q == SW'(STABLE_CYCLES - 1)) begin
          state_d = commit_ok ? StAccept : StReject;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      StAccept, StReject: state_d = StRelease;
      StRelease: if (!bottle_detect) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and counters; a clear coinciding with ACCEPT still applies the bottle
  always_comb begin
    accept_d = (state_q == StAccept);
    reject_d = (state_q == StReject);
    c250_d   = session_clear ? 12'd0 : c250_q;
    c500_d   = session_clear ? 12'd0 : c500_q;
    c1250_d  = session_clear ? 12'd0 : c1250_q;
    if (state_q == StAccept) begin
      unique case (last_q)
        2'b01:   c250_d  = c250_d + 12'd1;
        2'b10:   c500_d  = c500_d + 12'd1;
        2'b11:   c1250_d = c1250_d + 12'd1;
        default: ;
      endcase
    end
  end

`ifdef BOTTLE_CREDIT_CAP_EN
  always_comb begin
    credit_d = session_clear ? 14'd0 : credit_q;
    if (state_q == StAccept) credit_d = credit_d + weight;
  end
`endif

  assign bottle_250ml_counter  = c250_q;
  assign bottle_500ml_counter  = c500_q;
  assign bottle_1250ml_counter = c1250_q;
  assign bottle_accept         = accept_q;
  assign bottle_reject         = reject_q;
  assign busy                  = (state_q != StIdle);

endmodule
